// File: rtl/rps_pkg.sv
// rps_pkg: shared throw/state encodings and throw comparison helpers
package rps_pkg;
  typedef enum logic [2:0] {
    NONE     = 3'b000,
    ROCK     = 3'b001,
    PAPER    = 3'b010,
    SCISSORS = 3'b100
  } throw_t;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COLLECT    = 3'd1,
    REVEAL     = 3'd2,
    SCORE      = 3'd3,
    MATCH_OVER = 3'd4
  } state_t;
  function automatic logic is_valid(logic [2:0] t);
    return $onehot(t);
  endfunction
  function automatic logic beats(logic [2:0] a, logic [2:0] b);
    return (a == ROCK && b == SCISSORS) || (a == PAPER && b == ROCK) || (a == SCISSORS && b == PAPER);
  endfunction
endpackage

// File: rtl/rps_round_judge.sv
// rps_round_judge: combinational round judge; throws_i (3 bits/player) -> winners_o mask, draw_o
module rps_round_judge
  import rps_pkg::*;
#(
  parameter int N_PLAYERS = 2
) (
  input  logic [3*N_PLAYERS-1:0] throws_i,
  output logic [N_PLAYERS-1:0]   winners_o,
  output logic                   draw_o
);
  logic [N_PLAYERS-1:0] valid, beat;
  logic [2:0] present, t;
  int nvalid, ntypes;
  always_comb begin
    valid = '0;
    beat = '0;
    present = '0;
    t = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      t = throws_i[3*p +: 3];
      valid[p] = is_valid(t);
      present |= valid[p] ? t : 3'b000;
    end
    for (int p = 0; p < N_PLAYERS; p++) begin
      t = throws_i[3*p +: 3];
      beat[p] = valid[p] && beats(t, present & ~t);
    end
    nvalid = $countones(valid);
    ntypes = $countones(present);
    draw_o = nvalid == 0 || (nvalid > 1 && ntypes != 2);
    winners_o = nvalid == 1 ? valid : ntypes == 2 ? beat : '0;
  end
endmodule

// File: rtl/rps_match_ctrl.sv
// rps_match_ctrl: RPS match FSM; clk_i/reset/tick_i/go_i/throw_i in -> state, reveal display, round and match results out
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int WIN_SCORE = 3,
  parameter int STABLE_TICKS = 2,
  parameter int TIMEOUT_TICKS = 50,
  parameter int DISP_TICKS = 5,
  localparam int SCORE_W = $clog2(WIN_SCORE + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset,
  input  logic                         tick_i,
  input  logic                         go_i,
  input  logic [3*N_PLAYERS-1:0]       throw_i,
  output logic [2:0]                   state_o,
  output logic [1:0]                   disp_idx_o,
  output logic [2:0]                   disp_throw_o,
  output logic [N_PLAYERS-1:0]         winners_o,
  output logic                         draw_o,
  output logic                         round_done_o,
  output logic [SCORE_W*N_PLAYERS-1:0] scores_o,
  output logic [N_PLAYERS-1:0]         match_winner_o
);
  localparam int ST_W = $clog2(STABLE_TICKS + 1);
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int DT_W = $clog2(DISP_TICKS + 1);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STABLE_TICKS);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_TICKS);
  localparam logic [DT_W-1:0] DT_MAX = DT_W'(DISP_TICKS);
  localparam logic [1:0] LAST = 2'(N_PLAYERS - 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  state_t state_q, state_d;
  logic [ST_W-1:0] stable_q, stable_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [DT_W-1:0] dt_q, dt_d;
  logic [1:0] idx_q, idx_d;
  logic [3*N_PLAYERS-1:0] prev_q, latch_q, latch_d;
  logic [N_PLAYERS-1:0] win_q, win_d, match_q, match_d, judge_win;
  logic draw_q, draw_d, judge_draw, all_valid;
  logic [SCORE_W*N_PLAYERS-1:0] scores_q, scores_d;
  logic [SCORE_W-1:0] s;
  rps_round_judge #(.N_PLAYERS(N_PLAYERS)) u_judge (
    .throws_i (latch_q),
    .winners_o(judge_win),
    .draw_o   (judge_draw)
  );
  always_comb begin
    state_d = state_q;
    stable_d = stable_q;
    to_d = to_q;
    dt_d = dt_q;
    idx_d = idx_q;
    latch_d = latch_q;
    win_d = win_q;
    draw_d = draw_q;
    scores_d = scores_q;
    match_d = match_q;
    s = '0;
    all_valid = 1'b1;
    for (int p = 0; p < N_PLAYERS; p++) all_valid &= is_valid(throw_i[3*p +: 3]);
    case (state_q)
      IDLE: if (go_i) begin
        state_d = COLLECT;
        stable_d = '0;
        to_d = '0;
      end
      COLLECT: begin
        stable_d = (!all_valid || throw_i != prev_q) ? '0 : stable_q + ST_W'(tick_i);
        to_d = to_q + TO_W'(tick_i);
        if (stable_d == ST_MAX || to_d == TO_MAX) begin
          state_d = REVEAL;
          latch_d = throw_i;
          idx_d = '0;
          dt_d = '0;
        end
      end
      REVEAL: if (tick_i) begin
        dt_d = dt_q + DT_W'(1);
        if (dt_d == DT_MAX) begin
          dt_d = '0;
          if (idx_q == LAST) begin
            state_d = SCORE;
            win_d = judge_win;
            draw_d = judge_draw;
          end else idx_d = idx_q + 2'd1;
        end
      end
      SCORE: begin
        for (int p = 0; p < N_PLAYERS; p++) begin
          s = scores_q[SCORE_W*p +: SCORE_W];
          s = (win_q[p] && s != WIN) ? s + SCORE_W'(1) : s;
          scores_d[SCORE_W*p +: SCORE_W] = s;
          match_d[p] = s == WIN;
        end
        state_d = |match_d ? MATCH_OVER : COLLECT;
        stable_d = '0;
        to_d = '0;
      end
      MATCH_OVER: if (go_i) begin
        state_d = COLLECT;
        scores_d = '0;
        win_d = '0;
        draw_d = 1'b0;
        match_d = '0;
        stable_d = '0;
        to_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= IDLE;
      stable_q <= '0;
      to_q <= '0;
      dt_q <= '0;
      idx_q <= '0;
      prev_q <= '0;
      latch_q <= '0;
      win_q <= '0;
      draw_q <= 1'b0;
      scores_q <= '0;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      stable_q <= stable_d;
      to_q <= to_d;
      dt_q <= dt_d;
      idx_q <= idx_d;
      prev_q <= throw_i;
      latch_q <= latch_d;
      win_q <= win_d;
      draw_q <= draw_d;
      scores_q <= scores_d;
      match_q <= match_d;
    end
  end
  assign state_o = state_q;
  assign disp_idx_o = idx_q;
  assign disp_throw_o = state_q == REVEAL ? 3'(latch_q >> (3 * idx_q)) : 3'b000;
  assign winners_o = win_q;
  assign draw_o = draw_q;
  assign round_done_o = state_q == SCORE;
  assign scores_o = scores_q;
  assign match_winner_o = match_q;
endmodule

// File: tb/tb_rps_match_ctrl.sv
// tb_rps_match_ctrl: randomized round-level check of rps_match_ctrl and a 3-player judge against a behavioural model
module tb_rps_match_ctrl;
  localparam int N = 2, WS = 2, ST = 2, TO = 10, DT = 3, SW = $clog2(WS + 1);
  localparam int ROUNDS = 40;
  logic clk = 1'b0, reset = 1'b1, tick_i = 1'b0, go_i = 1'b0;
  logic [3*N-1:0] throw_i = '0;
  logic [2:0] state_o, disp_throw_o;
  logic [1:0] disp_idx_o;
  logic [N-1:0] winners_o, match_winner_o;
  logic draw_o, round_done_o;
  logic [SW*N-1:0] scores_o;
  logic [8:0] j3_t = '0;
  logic [2:0] j3_w;
  logic j3_d;
  int n_chk = 0, n_fail = 0, tcnt = 0;
  int sc[N];
  logic [3*N-1:0] thr[ROUNDS];
  int kd[ROUNDS];
  rps_match_ctrl #(
    .N_PLAYERS(N), .WIN_SCORE(WS), .STABLE_TICKS(ST), .TIMEOUT_TICKS(TO), .DISP_TICKS(DT)
  ) dut (
    .clk_i(clk), .reset(reset), .tick_i(tick_i), .go_i(go_i), .throw_i(throw_i),
    .state_o(state_o), .disp_idx_o(disp_idx_o), .disp_throw_o(disp_throw_o),
    .winners_o(winners_o), .draw_o(draw_o), .round_done_o(round_done_o),
    .scores_o(scores_o), .match_winner_o(match_winner_o)
  );
  rps_round_judge #(.N_PLAYERS(3)) u_j3 (.throws_i(j3_t), .winners_o(j3_w), .draw_o(j3_d));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    go_i = 1'b0;
    tick_i = (tcnt % 4 == 3);
    tcnt++;
  endtask
  // kinds: 0 rock, 1 paper, 2 scissors; kind k beats kind (k+2)%3
  function automatic void judge_model(input int np, input logic [11:0] t, output logic [3:0] w, output logic d);
    int kind[4];
    int pres[3];
    int nv, nk;
    logic [2:0] v;
    nv = 0;
    nk = 0;
    pres = '{0, 0, 0};
    w = '0;
    d = 1'b0;
    for (int p = 0; p < np; p++) begin
      v = t[3*p +: 3];
      kind[p] = v == 3'b001 ? 0 : v == 3'b010 ? 1 : v == 3'b100 ? 2 : -1;
      if (kind[p] >= 0) begin
        nv++;
        pres[kind[p]] = 1;
      end
    end
    for (int k = 0; k < 3; k++) nk += pres[k];
    if (nv == 0) d = 1'b1;
    else if (nv == 1) begin
      for (int p = 0; p < np; p++) if (kind[p] >= 0) w[p] = 1'b1;
    end else if (nk == 2) begin
      for (int p = 0; p < np; p++) if (kind[p] >= 0 && pres[(kind[p] + 2) % 3] == 1) w[p] = 1'b1;
    end else d = 1'b1;
  endfunction
  function automatic logic [2:0] rnd_thr();
    int r;
    r = $urandom_range(0, 11);
    return r < 9 ? 3'(1 << (r % 3)) : r == 9 ? 3'b000 : r == 10 ? 3'b011 : 3'b111;
  endfunction
  task automatic run_round(input int kind, input bit go_rev, input logic [3*N-1:0] nxt);
    int nt, rt, g, exp_lock;
    bit ct, gone, over;
    logic [3*N-1:0] lat;
    logic [2:0] alt, tmp;
    logic [3:0] ew;
    logic ed;
    logic [SW*N-1:0] es;
    logic [N-1:0] em;
    nt = 0;
    rt = 0;
    g = 0;
    gone = 0;
    lat = throw_i;
    exp_lock = (kind == 0 && $onehot(throw_i[2:0]) && $onehot(throw_i[5:3])) ? ST : TO;
    alt = throw_i[5:3] == 3'b010 ? 3'b100 : 3'b010;
    while (state_o == 3'd1 && g < 400) begin
      ct = tick_i;
      lat = throw_i;
      step();
      g++;
      if (ct) begin
        nt++;
        if (kind == 1 && state_o == 3'd1) begin
          tmp = throw_i[5:3];
          throw_i[5:3] = alt;
          alt = tmp;
        end
      end
    end
    check("lock_state", state_o, 2);
    check("lock_ticks", nt, exp_lock);
    judge_model(N, 12'(lat), ew, ed);
    throw_i = nxt;
    while (state_o == 3'd2 && g < 400) begin
      check("disp_idx", disp_idx_o, rt / DT);
      check("disp_throw", disp_throw_o, lat[3*(rt/DT) +: 3]);
      if (go_rev && !gone) begin
        go_i = 1'b1;
        gone = 1;
      end
      ct = tick_i;
      step();
      g++;
      if (ct) rt++;
    end
    check("reveal_ticks", rt, N * DT);
    check("score_state", state_o, 3);
    check("round_done", round_done_o, 1);
    check("winners", winners_o, ew[N-1:0]);
    check("draw", draw_o, ed);
    check("disp_blank_score", disp_throw_o, 0);
    over = 0;
    es = '0;
    em = '0;
    for (int p = 0; p < N; p++) begin
      if (ew[p] && sc[p] < WS) sc[p]++;
      es[SW*p +: SW] = SW'(sc[p]);
      em[p] = sc[p] == WS;
      over |= em[p];
    end
    step();
    check("round_done_clr", round_done_o, 0);
    check("scores", scores_o, es);
    check("next_state", state_o, over ? 4 : 1);
    if (over) check("match_winner", match_winner_o, em);
  endtask
  initial begin
    logic [3:0] w3;
    logic d3;
    int g;
    for (int p = 0; p < N; p++) sc[p] = 0;
    thr[0] = {3'b100, 3'b001};
    thr[1] = {3'b100, 3'b001};
    thr[2] = {3'b011, 3'b010};
    thr[3] = {3'b000, 3'b000};
    thr[4] = {3'b010, 3'b001};
    thr[5] = {3'b010, 3'b001};
    kd[0] = 0;
    kd[1] = 1;
    for (int i = 2; i < 6; i++) kd[i] = 0;
    for (int i = 6; i < ROUNDS; i++) begin
      thr[i] = {rnd_thr(), rnd_thr()};
      kd[i] = $urandom_range(0, 3) == 0 ? 1 : 0;
    end
    throw_i = thr[0];
    repeat (3) step();
    reset = 1'b0;
    check("rst_state", state_o, 0);
    check("rst_scores", scores_o, 0);
    check("rst_disp", disp_throw_o, 0);
    go_i = 1'b1;
    step();
    check("go_idle", state_o, 1);
    g = 0;
    while (state_o != 3'd2 && g < 200) begin
      step();
      g++;
    end
    check("pre_rst_reveal", state_o, 2);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_state", state_o, 0);
    check("midrst_scores", scores_o, 0);
    check("midrst_disp", disp_throw_o, 0);
    check("midrst_idx", disp_idx_o, 0);
    check("midrst_win", winners_o, 0);
    check("midrst_draw", draw_o, 0);
    check("midrst_match", match_winner_o, 0);
    check("midrst_done", round_done_o, 0);
    go_i = 1'b1;
    step();
    check("go_restart", state_o, 1);
    for (int i = 0; i < ROUNDS; i++) begin
      run_round(kd[i], i % 3 == 1, i < ROUNDS - 1 ? thr[i+1] : thr[i]);
      if (state_o == 3'd4) begin
        check("over_disp", disp_throw_o, 0);
        go_i = 1'b1;
        step();
        check("over_go_state", state_o, 1);
        check("over_go_scores", scores_o, 0);
        check("over_go_win", winners_o, 0);
        check("over_go_draw", draw_o, 0);
        check("over_go_match", match_winner_o, 0);
        for (int p = 0; p < N; p++) sc[p] = 0;
      end
    end
    j3_t = {3'b100, 3'b010, 3'b001};
    #1;
    check("j3_all_draw", j3_d, 1);
    check("j3_all_win", j3_w, 0);
    j3_t = {3'b001, 3'b010, 3'b010};
    #1;
    check("j3_paper_win", j3_w, 3'b011);
    check("j3_paper_draw", j3_d, 0);
    for (int i = 0; i < 30; i++) begin
      j3_t = {rnd_thr(), rnd_thr(), rnd_thr()};
      #1;
      judge_model(3, 12'(j3_t), w3, d3);
      check("j3_rand_win", j3_w, w3[2:0]);
      check("j3_rand_draw", j3_d, d3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
